// File: rtl/wshb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter (NUM_MASTERS -> 1 slave); grant registered, slave cycle 1 clk after request, GAP+IDLE per handover.
// Losing masters get no ack and must hold cyc; optional `WSHB_ARB_QUANTUM_EN preempts an owner after QUANTUM acks.
module wshb_arbiter_rr #(
    parameter int                     NUM_MASTERS = 3,
    parameter int                     ADR_W       = 32,
    parameter int                     DAT_W       = 16,
    parameter logic [NUM_MASTERS-1:0] PRIO_MASK   = '0
`ifdef WSHB_ARB_QUANTUM_EN
    ,
    parameter int                     QUANTUM     = 64
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MASTERS-1:0]         m_cyc,
    input  logic [NUM_MASTERS-1:0]         m_stb,
    input  logic [NUM_MASTERS-1:0]         m_we,
    input  logic [NUM_MASTERS*ADR_W-1:0]   m_adr,
    input  logic [NUM_MASTERS*(DAT_W/8)-1:0] m_sel,
    input  logic [NUM_MASTERS*3-1:0]       m_cti,
    input  logic [NUM_MASTERS*2-1:0]       m_bte,
    input  logic [NUM_MASTERS*DAT_W-1:0]   m_dat_ms,
    output logic [DAT_W-1:0]               m_dat_sm,
    output logic [NUM_MASTERS-1:0]         m_ack,
    output logic                           s_cyc,
    output logic                           s_stb,
    output logic                           s_we,
    output logic [ADR_W-1:0]               s_adr,
    output logic [DAT_W/8-1:0]             s_sel,
    output logic [2:0]                     s_cti,
    output logic [1:0]                     s_bte,
    output logic [DAT_W-1:0]               s_dat_ms,
    input  logic [DAT_W-1:0]               s_dat_sm,
    input  logic                           s_ack,
    output logic [NUM_MASTERS-1:0]         grant
);

    localparam int SEL_W = DAT_W / 8;
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       last_ptr;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W-1:0]       cand_idx;
    logic [NUM_MASTERS-1:0] eligible;
    logic                   win_found;
    logic                   release_own;
    logic                   preempt;

    // High-priority requesters shadow everyone else; search starts just after the last owner.
    always_comb begin
        eligible  = (|(m_cyc & PRIO_MASK)) ? (m_cyc & PRIO_MASK) : m_cyc;
        win_idx   = '0;
        win_found = 1'b0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_idx = IDX_W'((int'(last_ptr) + k) % NUM_MASTERS);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign release_own = !m_cyc[owner];

`ifdef WSHB_ARB_QUANTUM_EN
    localparam int CNT_W = $clog2(QUANTUM + 1);

    logic [CNT_W-1:0] ack_cnt;
    logic             others_req;

    assign others_req = |(m_cyc & ~grant);
    // Preempt on the ack that brings the count to QUANTUM (or any later ack once saturated).
    assign preempt    = (state == OWN) && s_ack && others_req &&
                        (ack_cnt >= CNT_W'(QUANTUM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt <= '0;
        end else if (state == IDLE) begin
            ack_cnt <= '0;
        end else if ((state == OWN) && s_ack && (ack_cnt != CNT_W'(QUANTUM))) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|m_cyc) state_nxt = OWN;
            OWN:     if (release_own || preempt) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            owner    <= '0;
            last_ptr <= IDX_W'(NUM_MASTERS - 1);
        end else if ((state == IDLE) && (state_nxt == OWN)) begin
            owner <= win_idx;
            grant <= NUM_MASTERS'(1) << win_idx;
        end else if ((state == OWN) && (state_nxt == GAP)) begin
            last_ptr <= owner;
            grant    <= '0;
        end
    end

    // Address/data follow the owner pointer at all times; only the handshake bits are gated by OWN.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        m_ack    = '0;
        s_adr    = m_adr[owner*ADR_W +: ADR_W];
        s_sel    = m_sel[owner*SEL_W +: SEL_W];
        s_cti    = m_cti[owner*3 +: 3];
        s_bte    = m_bte[owner*2 +: 2];
        s_dat_ms = m_dat_ms[owner*DAT_W +: DAT_W];
        m_dat_sm = s_dat_sm;
        if (state == OWN) begin
            s_cyc        = m_cyc[owner];
            s_stb        = m_stb[owner];
            s_we         = m_we[owner];
            m_ack[owner] = s_ack;
        end
    end

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Directed bench for wshb_arbiter_rr: two instances (no priority / master 1 high priority) share all inputs.
module tb_wshb_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*SW-1:0] m_sel;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [N*DW-1:0] m_dat_ms;
    logic [DW-1:0]   s_dat_sm;
    logic            s_ack;

    logic [DW-1:0]   m_dat_sm, p_m_dat_sm;
    logic [N-1:0]    m_ack, p_m_ack, grant, p_grant;
    logic            s_cyc, s_stb, s_we, p_s_cyc, p_s_stb, p_s_we;
    logic [AW-1:0]   s_adr, p_s_adr;
    logic [SW-1:0]   s_sel, p_s_sel;
    logic [2:0]      s_cti, p_s_cti;
    logic [1:0]      s_bte, p_s_bte;
    logic [DW-1:0]   s_dat_ms, p_s_dat_ms;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wshb_arbiter_rr #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .PRIO_MASK(3'b000)
`ifdef WSHB_ARB_QUANTUM_EN
        , .QUANTUM(4)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_dat_ms(m_dat_ms), .m_dat_sm(m_dat_sm),
        .m_ack(m_ack), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_cti(s_cti), .s_bte(s_bte), .s_dat_ms(s_dat_ms), .s_dat_sm(s_dat_sm), .s_ack(s_ack),
        .grant(grant)
    );

    wshb_arbiter_rr #(.NUM_MASTERS(N), .ADR_W(AW), .DAT_W(DW), .PRIO_MASK(3'b010)
`ifdef WSHB_ARB_QUANTUM_EN
        , .QUANTUM(4)
`endif
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_dat_ms(m_dat_ms), .m_dat_sm(p_m_dat_sm),
        .m_ack(p_m_ack), .s_cyc(p_s_cyc), .s_stb(p_s_stb), .s_we(p_s_we), .s_adr(p_s_adr),
        .s_sel(p_s_sel), .s_cti(p_s_cti), .s_bte(p_s_bte), .s_dat_ms(p_s_dat_ms),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .grant(p_grant)
    );

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        m_adr    = '0;
        m_sel    = '0;
        m_cti    = '0;
        m_bte    = '0;
        m_dat_ms = '0;
        s_dat_sm = '0;
        s_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_vec++; if (s_cyc !== 1'b0) begin n_err++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc); end
        next_cycle();
        m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b1;
        @(negedge clk);
        n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL req_latency_grant: got %b want 000", grant); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (m_ack !== 3'b001) begin n_err++; $display("FAIL pre_reset_ack: got %b want 001", m_ack); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (s_cyc !== 1'b0) begin n_err++; $display("FAIL async_reset_s_cyc: got %b want 0", s_cyc); end
        n_vec++; if (m_ack !== 3'b000) begin n_err++; $display("FAIL async_reset_m_ack: got %b want 000", m_ack); end
        n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL async_reset_grant: got %b want 000", grant); end
        next_cycle();
        rst_n = 1'b1; s_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL post_reset_idle: got %b want 000", grant); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL post_reset_first_grant: got %b want 001", grant); end
        n_vec++; if (s_cyc !== 1'b1) begin n_err++; $display("FAIL post_reset_s_cyc: got %b want 1", s_cyc); end
    endtask

    task automatic test_round_robin();
        logic [2:0] req;
        logic [2:0] prev;
        logic [2:0] order [4];
        logic [2:0] want  [4];
        int         gaps  [4];
        int         acks  [3];
        int         nown;
        int         zrun;
        want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100; want[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin order[i] = '0; gaps[i] = 0; end
        for (int i = 0; i < 3; i++) acks[i] = 0;
        do_reset();
        req = 3'b111; prev = '0; nown = 0; zrun = 0;
        for (int c = 0; c < 200 && nown < 4; c++) begin
            m_cyc = req; m_stb = req;
            #1 s_ack = s_cyc & s_stb;
            @(negedge clk);
            if (grant !== 3'b000 && grant !== prev) begin
                order[nown] = grant; gaps[nown] = zrun; nown++;
            end
            zrun = (grant === 3'b000) ? zrun + 1 : 0;
            prev = grant;
            // Each master drops cyc for one cycle after its 4th ack, then requests again.
            for (int i = 0; i < 3; i++) begin
                if (m_ack[i]) acks[i]++;
                if (!req[i]) req[i] = 1'b1;
                else if (acks[i] >= 4) begin req[i] = 1'b0; acks[i] = 0; end
            end
            next_cycle();
        end
        n_vec++; if (nown !== 4) begin n_err++; $display("FAIL rr_owner_count: got %0d want 4", nown); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (order[i] !== want[i]) begin n_err++; $display("FAIL rr_order[%0d]: got %b want %b", i, order[i], want[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            n_vec++; if (gaps[i] !== 2) begin n_err++; $display("FAIL rr_gap[%0d]: got %0d want 2", i, gaps[i]); end
        end
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    endtask

    task automatic test_priority();
        bit found;
        do_reset();
        m_cyc = 3'b011; m_stb = 3'b011;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_vec++; if (p_grant !== 3'b010) begin n_err++; $display("FAIL prio_first: got %b want 010", p_grant); end
        n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL noprio_first: got %b want 001", grant); end
        next_cycle();
        m_cyc = 3'b001; m_stb = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (p_grant === 3'b001) begin found = 1'b1; break; end
            next_cycle();
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL prio_m0_owns: got %b want 001", p_grant); end
        next_cycle();
        m_cyc = 3'b000; m_stb = 3'b000;
        next_cycle();
        m_cyc = 3'b011; m_stb = 3'b011;
        @(negedge clk);
        n_vec++; if (p_grant !== 3'b000) begin n_err++; $display("FAIL prio_gap: got %b want 000", p_grant); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (p_grant !== 3'b000) begin n_err++; $display("FAIL prio_idle: got %b want 000", p_grant); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (p_grant !== 3'b010) begin n_err++; $display("FAIL prio_last0: got %b want 010", p_grant); end
        next_cycle();
        m_cyc = '0; m_stb = '0;
    endtask

    task automatic test_ack_isolation();
        int  p2;
        int  other;
        bit  found;
        do_reset();
        m_adr    = {32'h3000_0008, 32'h2000_0004, 32'h1000_0000};
        m_we     = 3'b100;
        m_sel    = {2'b10, 2'b01, 2'b11};
        m_cti    = {3'b010, 3'b111, 3'b000};
        m_bte    = {2'b01, 2'b00, 2'b10};
        m_dat_ms = {16'hC0DE, 16'hBEEF, 16'h1234};
        s_dat_sm = 16'h5A5A;
        m_cyc = 3'b100; m_stb = 3'b100;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant === 3'b100) begin found = 1'b1; break; end
            next_cycle();
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL iso_grant: got %b want 100", grant); end
        n_vec++; if (s_adr !== 32'h3000_0008) begin n_err++; $display("FAIL iso_s_adr: got %h want 30000008", s_adr); end
        n_vec++; if (s_dat_ms !== 16'hC0DE) begin n_err++; $display("FAIL iso_s_dat_ms: got %h want c0de", s_dat_ms); end
        n_vec++; if ({s_we, s_sel, s_cti, s_bte} !== {1'b1, 2'b10, 3'b010, 2'b01}) begin
            n_err++; $display("FAIL iso_ctrl: got %b want 11001001", {s_we, s_sel, s_cti, s_bte});
        end
        n_vec++; if (m_dat_sm !== 16'h5A5A) begin n_err++; $display("FAIL iso_m_dat_sm: got %h want 5a5a", m_dat_sm); end
        p2 = 0; other = 0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            s_ack = ((k % 2) == 0);
            @(negedge clk);
            if (m_ack[2]) p2++;
            if (m_ack[1:0] !== 2'b00) other++;
        end
        n_vec++; if (p2 !== 5) begin n_err++; $display("FAIL iso_ack2_count: got %0d want 5", p2); end
        n_vec++; if (other !== 0) begin n_err++; $display("FAIL iso_ack_other: got %0d want 0", other); end
    endtask

    // Continues from test_ack_isolation with master 2 still owning the bus.
    task automatic test_ack_release();
        next_cycle();
        m_cyc = 3'b011; m_stb = 3'b011; s_ack = 1'b1;
        @(negedge clk);
        n_vec++; if (m_ack !== 3'b100) begin n_err++; $display("FAIL rel_ack_delivered: got %b want 100", m_ack); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (s_cyc !== 1'b0) begin n_err++; $display("FAIL rel_gap_s_cyc: got %b want 0", s_cyc); end
        n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL rel_gap_grant: got %b want 000", grant); end
        n_vec++; if (m_ack !== 3'b000) begin n_err++; $display("FAIL rel_gap_stray_ack: got %b want 000", m_ack); end
        next_cycle();
        s_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (grant !== 3'b000) begin n_err++; $display("FAIL rel_idle_grant: got %b want 000", grant); end
        next_cycle();
        @(negedge clk);
        n_vec++; if (grant !== 3'b001) begin n_err++; $display("FAIL rel_next_owner: got %b want 001", grant); end
        next_cycle();
        m_cyc = '0; m_stb = '0;
    endtask

`ifdef WSHB_ARB_QUANTUM_EN
    task automatic test_quantum();
        int acks0, low, a1;
        bit found, seen, back, resumed;
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant === 3'b001) begin found = 1'b1; break; end
            next_cycle();
        end
        n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL q_m0_grant: got %b want 001", grant); end
        acks0 = 0; low = 0; a1 = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            m_cyc = 3'b011; m_stb = 3'b011;
            #1 s_ack = s_cyc & s_stb;
            @(negedge clk);
            if (grant === 3'b010) begin seen = 1'b1; a1 = m_ack[1] ? 1 : 0; break; end
            if (m_ack[0]) acks0++;
            if (!s_cyc && acks0 > 0) low++;
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL q_m1_grant: got %b want 010", grant); end
        n_vec++; if (acks0 !== 4) begin n_err++; $display("FAIL q_m0_acks: got %0d want 4", acks0); end
        n_vec++; if (low !== 2) begin n_err++; $display("FAIL q_idle_cycles: got %0d want 2", low); end
        back = 1'b0; resumed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            m_cyc = (a1 < 2) ? 3'b011 : 3'b001; m_stb = m_cyc;
            #1 s_ack = s_cyc & s_stb;
            @(negedge clk);
            if (grant === 3'b001) begin back = 1'b1; resumed = m_ack[0]; break; end
            if (m_ack[1]) a1++;
        end
        n_vec++; if (back !== 1'b1) begin n_err++; $display("FAIL q_m0_regrant: got %b want 001", grant); end
        n_vec++; if (resumed !== 1'b1) begin n_err++; $display("FAIL q_m0_resume_ack: got %b want 1", resumed); end
        next_cycle();
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_ack_isolation();
        test_ack_release();
`ifdef WSHB_ARB_QUANTUM_EN
        test_quantum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wshb_arbiter_rr.md
Name: wshb_arbiter_rr

Overview:
- Parametrised Wishbone B3 interconnect: NUM_MASTERS masters share one slave, typically the SDRAM controller.
- Successor to the two-master mire/VGA interconnect.
- Arbitration is round-robin with a registered grant, an enforced idle gap between owners and an optional per-master priority override.
- Sits between the frame producers/consumers and the SDRAM Wishbone port.

Parameters:
- NUM_MASTERS, 3, number of master ports (2..8).
- ADR_W, 32, address width.
- DAT_W, 16, data width; SEL_W = DAT_W/8.
- PRIO_MASK, 0, NUM_MASTERS-bit mask; a set bit marks a master as high priority (the VGA read path).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_cyc  in  NUM_MASTERS  per-master cyc
- m_stb  in  NUM_MASTERS  per-master stb
- m_we  in  NUM_MASTERS  per-master we
- m_adr  in  NUM_MASTERS*ADR_W  packed addresses; master i at [i*ADR_W +: ADR_W]
- m_sel  in  NUM_MASTERS*SEL_W  packed byte selects
- m_cti  in  NUM_MASTERS*3  packed cti
- m_bte  in  NUM_MASTERS*2  packed bte
- m_dat_ms  in  NUM_MASTERS*DAT_W  packed write data
- m_dat_sm  out  DAT_W  read data, broadcast to all masters
- m_ack  out  NUM_MASTERS  per-master ack
- s_cyc, s_stb, s_we  out  1  slave controls
- s_adr  out  ADR_W  slave address
- s_sel  out  SEL_W  slave byte selects
- s_cti  out  3  slave cti
- s_bte  out  2  slave bte
- s_dat_ms  out  DAT_W  slave write data
- s_dat_sm  in  DAT_W  slave read data
- s_ack  in  1  slave ack
- grant  out  NUM_MASTERS  one-hot current owner, all-zero when none (debug/verification)

Behaviour:
- State machine: IDLE, OWN, GAP. All state, grant and last-owner pointer are registered.
- Reset (rst_n low, asynchronous):
  - state = IDLE, grant = 0, last pointer = NUM_MASTERS-1.
  - All s_* control outputs 0 and m_ack = 0, valid immediately, with no clock edge needed.
- IDLE: if any m_cyc is high at an edge, go to OWN with grant = the winner.
  - Winner: if any requesting master has its PRIO_MASK bit set, round-robin among those only.
  - Otherwise round-robin among all requesters.
  - Round-robin search starts at last pointer + 1 and wraps modulo NUM_MASTERS.
- OWN: the s_* controls mux combinationally from the granted master. m_ack[g] = s_ack; every other m_ack bit is 0.
  - Latency: request seen at edge t; s_cyc high in cycle t+1. No combinational path from m_cyc to grant.
- Release: when m_cyc[g] is low at an edge, go to GAP and set last pointer = g.
  - In GAP, s_cyc = s_stb = 0 for exactly one cycle so the slave closes its cycle.
- GAP is always followed by IDLE, so every handover costs 2 idle cycles on the slave bus.
  - Requests that arrive during GAP are evaluated in IDLE; round-robin then naturally skips the master just served.
- Non-granted masters see m_ack = 0 and must hold their request. No request is ever dropped.
- s_dat_ms comes from the granted master; m_dat_sm = s_dat_sm unconditionally.
- A granted master that drops m_cyc in the same cycle as s_ack: the ack is delivered, then GAP.
- s_ack while the state is not OWN is ignored and is not forwarded.
- NUM_MASTERS = 1 degenerates to a pass-through with the one-cycle GAP retained.

Optional Feature:
- Macro: WSHB_ARB_QUANTUM_EN.
- When defined:
  - A parameter QUANTUM (default 64) and a per-grant ack counter are added.
  - When the counter reaches QUANTUM and any other master has m_cyc high, the arbiter forces GAP after that ack, even though the owner still holds cyc.
  - The preempted master sees no further ack until re-granted and resumes transparently.
  - The counter is cleared on every new grant.
- When not defined: ownership lasts until the owner drops m_cyc, and there is no counter logic.

Test Plan:
- Reset: assert rst_n low mid-transfer with m_cyc = 3'b111 -> s_cyc = 0, m_ack = 0 and grant = 0 in the same cycle; after release, first grant = 3'b001.
- Round-robin: NUM_MASTERS = 3, PRIO_MASK = 0, all masters hold cyc for 4-ack bursts -> grant order 001, 010, 100, 001, with exactly 2 idle cycles between owners.
- Priority: PRIO_MASK = 3'b010, masters 0 and 1 request together from IDLE -> master 1 granted first, even when the last pointer = 0.
- Ack isolation: master 2 owns the bus, s_ack pulses 5 times -> m_ack[2] pulses 5 times, m_ack[1:0] stay 0, and s_adr matches m_adr slice 2.
- Simultaneous ack and release: owner drops cyc in the same cycle as s_ack -> ack delivered, next cycle s_cyc = 0 (GAP).
- WSHB_ARB_QUANTUM_EN, QUANTUM = 4, master 0 streams continuously and master 1 requests -> after the 4th ack, s_cyc low for 2 cycles, master 1 granted, and master 0 regains the bus after master 1 releases.
